serial_word_receiver: RTL
=========================

// Module: serial_word_receiver
// PURPOSE
//  Receiving end of the MSB-first serial link driven by the team's parallel-load shift register.
//  Samples one bit per SerialEn cycle and assembles WIDTH-bit words.
//  Hands each completed word to a consumer over a valid/ready handshake through a one-word holding register.
//  FrameStart realigns word boundaries; Overrun flags words lost to a stalled consumer.
// PARAMETERS
//  WIDTH    4   bits per word; legal range 2..16
//  CNT_W    5   width of the BitCount port; must satisfy 2**CNT_W > WIDTH
// PORTS
//  Clk           in   1        single clock; everything updates on posedge
//  Reset         in   1        synchronous, active-high
//  SerialIn      in   1        serial data bit; MSB of each word arrives first
//  SerialEn      in   1        SerialIn is valid this cycle; shift it in
//  FrameStart    in   1        discard the partial word; see BEHAVIOUR
//  ParallelOut   out  WIDTH    held word; stable while OutValid=1
//  OutValid      out  1        ParallelOut holds an unconsumed word
//  OutReady      in   1        consumer accepts the word (transfer = OutValid & OutReady)
//  BitCount      out  CNT_W    bits of the current partial word received, 0..WIDTH-1
//  Overrun       out  1        sticky: a completed word was dropped
//  ClearOverrun  in   1        clears Overrun
// BEHAVIOUR
//  Reset: shift_reg, ParallelOut, BitCount, OutValid and Overrun all go to 0 on the next edge. Reset overrides every other input.
//    Reset mid-word discards the partial word and any held word.
//  Shift: when SerialEn=1, shift_reg <= {shift_reg[WIDTH-2:0], SerialIn} and BitCount increments.
//  FrameStart=1 with SerialEn=0: BitCount <= 0 and the partial word is discarded. The held word is unaffected.
//  FrameStart=1 with SerialEn=1: SerialIn becomes the MSB of a new word and BitCount <= 1.
//    A completion pending in the same cycle is suppressed.
//  Completion: SerialEn=1, FrameStart=0 and BitCount==WIDTH-1.
//    BitCount wraps to 0. The word is {shift_reg[WIDTH-2:0], SerialIn}.
//  Output latency: the completed word appears on ParallelOut with OutValid=1 on the edge that samples the last bit.
//    It is therefore visible in the cycle after the last bit is presented.
//  Holding register: OutValid stays 1 and ParallelOut stays stable until a transfer occurs.
//    After a transfer with no new completion, OutValid <= 0. ParallelOut keeps its old value.
//  Completion when OutValid=0, or when a transfer happens in the same cycle: the new word loads and OutValid <= 1.
//    This gives back-to-back words with no bubble.
//  Completion when OutValid=1 and OutReady=0: the new word is dropped, the held word is kept and Overrun <= 1.
//  Overrun stays set until a cycle with ClearOverrun=1.
//    If ClearOverrun and a new drop occur in the same cycle, set wins.
//  OutReady while OutValid=0 is ignored.
//  Deserialization continues regardless of consumer stalls; the receiver never back-pressures SerialEn.
// STRUCTURE
//  Shared package rx_pkg holds the WIDTH default, the CNT_W derivation and the legal-range check constants.
//    The matching shift-register transmitter reuses these.
//  No sub-module is needed. Contents: one bit counter, one shift register, and the holding register with its valid/overrun flags.
//  The block has no explicit FSM. Its state is fully defined by BitCount and OutValid.
// TESTING (WIDTH=4)
//  1. Reset, then shift in 1,0,1,1 on consecutive SerialEn cycles with OutReady=1.
//     -> ParallelOut=4'hB with OutValid=1 for exactly one cycle, Overrun=0.
//  2. Send two words 4'hA and 4'h5 back-to-back with OutReady held at 0 until the second completes.
//     -> ParallelOut stays 4'hA, Overrun=1, BitCount=0.
//     Then raise OutReady for one cycle -> OutValid=0. Then pulse ClearOverrun -> Overrun=0.
//  3. Shift 1,1 and pulse FrameStart with SerialEn=1 and SerialIn=0, then shift 1,1,0.
//     -> the single word received is 4'h6.
//  4. With word 4'h3 held and OutReady=1, complete 4'hC in the same cycle as the transfer.
//     -> OutValid stays 1, ParallelOut=4'hC, Overrun=0.
//  5. Interleave SerialEn=0 gaps between the bits of 1,0,0,1.
//     -> ParallelOut=4'h9, and BitCount holds its value during the gaps.
//  6. Assert Reset after 3 bits, then send 0,1,1,1.
//     -> ParallelOut=4'h7, and all outputs are 0 in the cycle after Reset.

Source files
------------

// File: rtl/rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rx_pkg
//  Description : Shared constants for the MSB-first serial link. Holds the
//                default word width, the legal width range and a helper that
//                derives the minimum bit-counter width. The matching
//                parallel-load shift-register transmitter reuses these.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package rx_pkg;

  localparam int RX_WIDTH_DEFAULT = 4;
  localparam int RX_WIDTH_MIN     = 2;
  localparam int RX_WIDTH_MAX     = 16;
  localparam int RX_CNT_W_DEFAULT = 5;

  // Smallest counter width that can represent 0..width (2**w > width).
  function automatic int rx_min_cnt_w(input int width);
    int w;
    w = 1;
    while ((1 << w) <= width) begin
      w = w + 1;
    end
    return w;
  endfunction

  // True when a WIDTH/CNT_W pair is usable by the receiver and transmitter.
  function automatic bit rx_params_ok(input int width, input int cnt_w);
    return (width >= RX_WIDTH_MIN) && (width <= RX_WIDTH_MAX) &&
           (cnt_w >= rx_min_cnt_w(width));
  endfunction

endpackage : rx_pkg
`default_nettype wire

// File: rtl/serial_word_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : serial_word_receiver
//  Description : Receiving end of the MSB-first serial link. Shifts in one
//                bit per SerialEn cycle, assembles WIDTH-bit words and hands
//                each word to a consumer through a one-word holding register
//                with a valid/ready handshake. FrameStart realigns word
//                boundaries; Overrun is a sticky flag for dropped words.
//  Ports       : Clk, Reset           - clock, synchronous active-high reset
//                SerialIn, SerialEn   - serial bit and its qualifier
//                FrameStart           - discard partial word / start new word
//                ParallelOut,OutValid - held word and its valid flag
//                OutReady             - consumer accept (transfer = valid&ready)
//                BitCount             - bits of the partial word, 0..WIDTH-1
//                Overrun,ClearOverrun - sticky drop flag and its clear
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_word_receiver
  import rx_pkg::*;
#(
  parameter int WIDTH = RX_WIDTH_DEFAULT,
  parameter int CNT_W = RX_CNT_W_DEFAULT
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             SerialIn,
  input  logic             SerialEn,
  input  logic             FrameStart,
  output logic [WIDTH-1:0] ParallelOut,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [CNT_W-1:0] BitCount,
  output logic             Overrun,
  input  logic             ClearOverrun
);

  // Elaboration-time guard on the parameter pair.
  generate
    if (!rx_params_ok(WIDTH, CNT_W)) begin : g_bad_params
      $error("serial_word_receiver: illegal WIDTH/CNT_W combination");
    end
  endgenerate

  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

  logic [WIDTH-1:0] shift_reg_q,   shift_reg_d;
  logic [WIDTH-1:0] parallel_q,    parallel_d;
  logic [CNT_W-1:0] bit_count_q,   bit_count_d;
  logic             out_valid_q,   out_valid_d;
  logic             overrun_q,     overrun_d;

  logic             w_transfer;
  logic             w_complete;
  logic [WIDTH-1:0] w_word;

  assign w_transfer = out_valid_q & OutReady;
  // A FrameStart in the same cycle starts a new word, so it suppresses
  // any completion that would otherwise happen on this bit.
  assign w_complete = SerialEn & ~FrameStart & (bit_count_q == C_LAST_BIT);
  assign w_word     = {shift_reg_q[WIDTH-2:0], SerialIn};

  always_comb begin
    shift_reg_d = shift_reg_q;
    bit_count_d = bit_count_q;
    parallel_d  = parallel_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;

    // Bit counter and shift register. The receiver never stalls the link,
    // so this runs independently of the consumer.
    if (SerialEn) begin
      shift_reg_d = w_word;
      if (FrameStart) begin
        bit_count_d = C_ONE;
      end else if (w_complete) begin
        bit_count_d = '0;
      end else begin
        bit_count_d = bit_count_q + C_ONE;
      end
    end else if (FrameStart) begin
      bit_count_d = '0;
      shift_reg_d = '0;
    end

    // Holding register: a transfer frees the slot; a completion in the same
    // cycle refills it immediately so back-to-back words need no bubble.
    if (w_transfer) begin
      out_valid_d = 1'b0;
    end

    if (ClearOverrun) begin
      overrun_d = 1'b0;
    end

    if (w_complete) begin
      if (!out_valid_q || w_transfer) begin
        parallel_d  = w_word;
        out_valid_d = 1'b1;
      end else begin
        // Slot still occupied: drop the new word. Set beats clear.
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      shift_reg_q <= '0;
      bit_count_q <= '0;
      parallel_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      shift_reg_q <= shift_reg_d;
      bit_count_q <= bit_count_d;
      parallel_q  <= parallel_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign ParallelOut = parallel_q;
  assign OutValid    = out_valid_q;
  assign BitCount    = bit_count_q;
  assign Overrun     = overrun_q;

endmodule : serial_word_receiver
`default_nettype wire
